// File: rtl/fetch_buffer_pkg.sv
// Shared constants and types for the fetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_buffer_pkg;

  // Bubble presented to decode when the queue holds nothing (addi x0,x0,0).
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  // Occupancy classification derived from the pointers.
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

  // Queue entry is {fault, pc, word}.
  function automatic int entry_width(input int xlen);
    return 32 + xlen + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_ins_queue_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates the write enable.
module fetch_buffer_ins_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between I-cache and decode; presents oldest entry or a NOP bubble.
// Latency: a word pushed at edge N is visible on the outputs during cycle N+1 (no bypass).
// Backpressure: CACHE_READY drops when full (state only, no path from STALL_ENABLE); FLUSH drops all.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              CACHE_DATA,
  input  logic [XLEN-1:0]          CACHE_PC,
  input  logic                     CACHE_FAULT,
  input  logic                     CACHE_VALID,
  output logic                     CACHE_READY,
  input  logic                     STALL_ENABLE,
  input  logic                     FLUSH,
  output logic [31:0]              INSTRUCTION,
  output logic [XLEN-1:0]          PC_OUT,
  output logic                     FAULT_OUT,
  output logic                     INS_VALID,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = entry_width(XLEN);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  occ_state_t    occ;
  logic [EW-1:0] head_entry;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // Classify occupancy from the pointers; everything visible derives from this.
  always_comb begin
    occ = OCC_PARTIAL;
    if (empty)     occ = OCC_EMPTY;
    else if (full) occ = OCC_FULL;
  end

  // Ready is a function of stored state only, so a same-cycle pop never frees a slot.
  assign CACHE_READY = (occ != OCC_FULL) && !RST;
  assign INS_VALID   = (occ != OCC_EMPTY);

  // Flush overrides both sides, so a word offered alongside it is dropped.
  assign push = CACHE_VALID && CACHE_READY && !FLUSH;
  assign pop  = STALL_ENABLE && INS_VALID && !FLUSH;

  // Pointer update: reset and flush both return the queue to empty at index 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (FLUSH) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign COUNT = wr_ptr - rd_ptr;

  fetch_buffer_ins_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({CACHE_FAULT, CACHE_PC, CACHE_DATA}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head_entry)
  );

  // Mask the head with the bubble whenever nothing valid is queued.
  always_comb begin
    INSTRUCTION = NOP_INS;
    PC_OUT      = '0;
    FAULT_OUT   = 1'b0;
    if (INS_VALID) begin
      INSTRUCTION = head_entry[31:0];
      PC_OUT      = head_entry[32 +: XLEN];
      FAULT_OUT   = head_entry[EW-1];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer.
// Latency: inputs driven 1ns after each rising edge, outputs checked in the same window.
// Backpressure: exercised via full queue, held cache word, flush and reset.
module tb_fetch_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] CACHE_DATA;
  logic [63:0] CACHE_PC;
  logic        CACHE_FAULT;
  logic        CACHE_VALID;
  logic        CACHE_READY;
  logic        STALL_ENABLE;
  logic        FLUSH;
  logic [31:0] INSTRUCTION;
  logic [63:0] PC_OUT;
  logic        FAULT_OUT;
  logic        INS_VALID;
  logic [2:0]  COUNT;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(4), .XLEN(64)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CACHE_DATA   (CACHE_DATA),
    .CACHE_PC     (CACHE_PC),
    .CACHE_FAULT  (CACHE_FAULT),
    .CACHE_VALID  (CACHE_VALID),
    .CACHE_READY  (CACHE_READY),
    .STALL_ENABLE (STALL_ENABLE),
    .FLUSH        (FLUSH),
    .INSTRUCTION  (INSTRUCTION),
    .PC_OUT       (PC_OUT),
    .FAULT_OUT    (FAULT_OUT),
    .INS_VALID    (INS_VALID),
    .COUNT        (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(INS_VALID), 64'd0);
    chk({tag, ".ins"},   64'(INSTRUCTION), 64'h0000_0013);
    chk({tag, ".pc"},    PC_OUT, 64'd0);
    chk({tag, ".fault"}, 64'(FAULT_OUT), 64'd0);
    chk({tag, ".count"}, 64'(COUNT), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    CACHE_DATA = '0; CACHE_PC = '0; CACHE_FAULT = 1'b0; CACHE_VALID = 1'b0;
    STALL_ENABLE = 1'b0; FLUSH = 1'b0;
    #2;
    chk_empty("rst");
    chk("rst.ready", 64'(CACHE_READY), 64'd0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk_empty("idle");
    chk("idle.ready", 64'(CACHE_READY), 64'd1);

    // Single push, no pop
    CACHE_VALID = 1'b1; CACHE_PC = 64'h1000; CACHE_DATA = 32'h0050_0093;
    tick();
    CACHE_VALID = 1'b0;
    chk("one.valid", 64'(INS_VALID), 64'd1);
    chk("one.pc",    PC_OUT, 64'h1000);
    chk("one.ins",   64'(INSTRUCTION), 64'h0050_0093);
    chk("one.count", 64'(COUNT), 64'd1);
    STALL_ENABLE = 1'b1;
    tick();
    STALL_ENABLE = 1'b0;
    chk_empty("drain1");

    // Fill to capacity
    for (int i = 0; i < 4; i++) begin
      CACHE_VALID = 1'b1; CACHE_PC = 64'(4 * i); CACHE_DATA = 32'hA000_0000 | 32'(i);
      tick();
    end
    chk("full.count", 64'(COUNT), 64'd4);
    chk("full.ready", 64'(CACHE_READY), 64'd0);
    chk("full.pc",    PC_OUT, 64'h0);
    // Fifth word offered and held by the cache
    CACHE_PC = 64'h10; CACHE_DATA = 32'hA000_0004;
    tick();
    chk("fifth.count", 64'(COUNT), 64'd4);
    chk("fifth.pc",    PC_OUT, 64'h0);
    STALL_ENABLE = 1'b1;
    tick();
    STALL_ENABLE = 1'b0;
    chk("pop.pc",    PC_OUT, 64'h4);
    chk("pop.ins",   64'(INSTRUCTION), 64'hA000_0001);
    chk("pop.count", 64'(COUNT), 64'd3);
    chk("pop.ready", 64'(CACHE_READY), 64'd1);
    tick();
    chk("refill.count", 64'(COUNT), 64'd4);

    // Flush a full queue while a word is offered
    FLUSH = 1'b1; CACHE_VALID = 1'b1; CACHE_PC = 64'h200; CACHE_DATA = 32'hDEAD_BEEF;
    tick();
    FLUSH = 1'b0; CACHE_VALID = 1'b0;
    chk_empty("flush");
    tick();
    chk_empty("flush2");

    // Streaming push+pop for 10 words
    CACHE_VALID = 1'b1; CACHE_PC = 64'h0; CACHE_DATA = 32'hB000_0000;
    tick();
    chk("st0.pc",    PC_OUT, 64'h0);
    chk("st0.count", 64'(COUNT), 64'd1);
    for (int i = 1; i < 10; i++) begin
      CACHE_VALID = 1'b1; STALL_ENABLE = 1'b1;
      CACHE_PC = 64'(4 * i); CACHE_DATA = 32'hB000_0000 | 32'(i);
      tick();
      chk($sformatf("st%0d.pc", i),    PC_OUT, 64'(4 * i));
      chk($sformatf("st%0d.ins", i),   64'(INSTRUCTION), 64'hB000_0000 | 64'(i));
      chk($sformatf("st%0d.count", i), 64'(COUNT), 64'd1);
    end
    CACHE_VALID = 1'b0;
    tick();
    STALL_ENABLE = 1'b0;
    chk_empty("stend");

    // Faulting fetch then asynchronous reset mid-cycle
    CACHE_VALID = 1'b1; CACHE_FAULT = 1'b1; CACHE_PC = 64'h3000; CACHE_DATA = 32'h0000_0073;
    tick();
    CACHE_VALID = 1'b0; CACHE_FAULT = 1'b0;
    chk("flt.valid", 64'(INS_VALID), 64'd1);
    chk("flt.fault", 64'(FAULT_OUT), 64'd1);
    chk("flt.pc",    PC_OUT, 64'h3000);
    #2;
    RST = 1'b1;
    #1;
    chk_empty("arst");
    chk("arst.ready", 64'(CACHE_READY), 64'd0);
    tick();
    RST = 1'b0;
    #1;
    chk_empty("post");
    chk("post.ready", 64'(CACHE_READY), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between the instruction cache and the decode unit. Captures fetched words with their PC and fetch-fault flag, then presents the oldest one on `INSTRUCTION`/`PC_OUT` until decode consumes it. When the queue is empty it substitutes a NOP bubble. `FLUSH` discards every queued entry on a branch or trap redirect.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, ≥2.
- `XLEN`, 64: PC width.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `CACHE_DATA`  in  32  instruction word from the I-cache.
- `CACHE_PC`  in  XLEN  PC of `CACHE_DATA`.
- `CACHE_FAULT`  in  1  fetch access/page fault for this word.
- `CACHE_VALID`  in  1  cache offers a word this cycle.
- `CACHE_READY`  out  1  buffer accepts a word this cycle.
- `STALL_ENABLE`  in  1  decode advances this cycle; high means the head entry is consumed.
- `FLUSH`  in  1  redirect; discard all entries.
- `INSTRUCTION`  out  32  head word, or NOP when empty.
- `PC_OUT`  out  XLEN  head PC, or 0 when empty.
- `FAULT_OUT`  out  1  head fault flag, or 0 when empty.
- `INS_VALID`  out  1  head entry is valid.
- `COUNT`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular queue with read and write pointers, each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Full: the index bits are equal and the wrap bits differ. Empty: the pointers are equal.
- Push: `CACHE_VALID & CACHE_READY & !FLUSH`. Writes {`CACHE_FAULT`, `CACHE_PC`, `CACHE_DATA`} at the write index, then increments the write pointer.
- Pop: `STALL_ENABLE & INS_VALID & !FLUSH`. Increments the read pointer.
- Push and pop in the same cycle: both occur and `COUNT` is unchanged.
- `CACHE_READY` = `!full & !RST`. It depends on the current state only; a pop in the same cycle does not free a slot, so there is no combinational path from `STALL_ENABLE`.
- When full, `CACHE_VALID` is ignored. The cache must hold its word until `CACHE_READY` is high.
- `FLUSH` takes priority over push and pop. Next cycle both pointers are 0 and the queue is empty. A word offered during the `FLUSH` cycle is dropped, although `CACHE_READY` may read high.
- Empty outputs: `INS_VALID`=0, `INSTRUCTION`=`NOP_INS` (32'h0000_0013), `PC_OUT`=0, `FAULT_OUT`=0.
- Fault entries are queued and presented like normal entries. The buffer does not interpret them.
- Occupancy states: EMPTY (`COUNT`=0), PARTIAL, and FULL (`COUNT`=DEPTH). Transitions follow the push/pop/flush rules above; no other FSM exists.

## Timing
- Reset values, in effect while `RST` is high and on deassert:
  - pointers 0
  - `INS_VALID`=0, `INSTRUCTION`=`NOP_INS`, `PC_OUT`=0, `FAULT_OUT`=0, `COUNT`=0
  - `CACHE_READY`=0 while `RST`=1 and 1 on the first cycle after.
- Latency: a word pushed at edge N appears on `INSTRUCTION` after edge N, i.e. during cycle N+1. There is no same-cycle bypass.
- Outputs are combinational reads of registered storage and pointers. They are stable for the whole cycle.
- Throughput: 1 word/cycle in steady state with DEPTH≥2.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). Stored data contents are don't-care.
- Pointer wrap: the index rolls from DEPTH-1 to 0 and the wrap bit toggles. No entry is lost or duplicated.
- `FLUSH` and `RST` together: reset wins. The result is identical in either case.

## Structure
- `NOP_INS` and the entry width (32+XLEN+1) go in `PipelineParams.vh` next to the existing pipeline constants.
- Sub-module `INS_QUEUE_RAM`: DEPTH×entry register array with one write port and one asynchronous read port, no reset on data.
- Pointer, flag and `COUNT` logic lives in `fetch_buffer`.
- `INSTRUCTION` connects directly to the decode unit's instruction input. `STALL_ENABLE` comes from the pipeline stall network.

## Test plan
- Reset, then idle: `INS_VALID`=0, `INSTRUCTION`=32'h0000_0013, `CACHE_READY`=1, `COUNT`=0.
- Push PC 0x1000 word 0x00500093 with `STALL_ENABLE`=0: the next cycle shows `INS_VALID`=1, `PC_OUT`=0x1000, `INSTRUCTION`=0x00500093, `COUNT`=1.
- Push 4 words (PCs 0x0, 0x4, 0x8, 0xC) with no pops: `CACHE_READY`=0 and `COUNT`=4. A 5th offered word is not accepted. After one pop, `PC_OUT`=0x4 and `CACHE_READY`=1.
- Push and pop every cycle for 10 words: the PCs emerge in order 0x0…0x24, `COUNT` stays at 1, and the pointers wrap twice without loss.
- Full queue, assert `FLUSH` while `CACHE_VALID`=1 for PC 0x200: the next cycle is empty (NOP, `COUNT`=0). The PC 0x200 word is absent afterwards.
- Push a word with `CACHE_FAULT`=1 at PC 0x3000, then assert `RST` mid-cycle: the outputs return to reset values immediately. After release, `FAULT_OUT`=0 and the queue is empty.
